// File: rtl/serial_pair_serializer_msb_first.sv
// Parallel-to-serial front end for the serial comparators.
// Accepts a pair of WIDTH-bit words over valid/ready and issues a one-cycle
// comparator clear. It then shifts both words out in lock-step, one bit pair
// per clock, with first/last frame markers.
module serial_pair_serializer_msb_first #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             abort,
    output logic             cmp_clear,
    output logic             ser_valid,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_first,
    output logic             ser_last
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic             clear_q, clear_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;

    logic             at_last;
    logic             accept;

    // End-of-frame bit: the only SHIFT cycle in which a new pair may be taken.
    assign at_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    // Abort masks ready so an abandoned frame can never chain into a new one.
    assign in_ready = (state_q == IDLE) || (at_last && !abort);
    assign accept   = in_valid && in_ready;

    // Next-state, counter and shift-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    sh_a_d  = in_a;
                    sh_b_d  = in_b;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sh_a_d  = '0;
                    sh_b_d  = '0;
                end else begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sh_a_d  = '0;
                    sh_b_d  = '0;
                end else begin
                    if (MSB_FIRST) begin
                        sh_a_d = {sh_a_q[WIDTH-2:0], 1'b0};
                        sh_b_d = {sh_b_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
                        sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (accept) begin
                            state_d = CLEAR;
                            sh_a_d  = in_a;
                            sh_b_d  = in_b;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sh_a_d  = '0;
                sh_b_d  = '0;
            end
        endcase
    end

    // Frame flags are decoded from next state so they register alongside it.
    always_comb begin
        clear_d = (state_d == CLEAR);
        valid_d = (state_d == SHIFT);
        first_d = valid_d && (cnt_d == '0);
        last_d  = valid_d && (cnt_d == CNT_LAST);
    end

    // State, datapath and registered output flags; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            clear_q <= 1'b0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            clear_q <= clear_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    // The shift registers still hold the loaded pair during CLEAR, so the
    // serial bits are gated by the valid flag to read 0 outside SHIFT.
    assign cmp_clear = clear_q;
    assign ser_valid = valid_q;
    assign ser_first = first_q;
    assign ser_last  = last_q;
    assign ser_a     = valid_q && (MSB_FIRST ? sh_a_q[WIDTH-1] : sh_a_q[0]);
    assign ser_b     = valid_q && (MSB_FIRST ? sh_b_q[WIDTH-1] : sh_b_q[0]);

endmodule

// File: tb/tb_serial_pair_serializer_msb_first.sv
// Scoreboard bench for serial_pair_serializer_msb_first: one MSB-first and one
// LSB-first instance. Stimulus pushes expected frame items; a negedge monitor
// pops and compares whenever an instance shows cmp_clear or ser_valid.
module tb_serial_pair_serializer_msb_first;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic         m_valid, m_ready, m_abort, m_clr, m_sv, m_sa, m_sb, m_sf, m_sl;
    logic [W-1:0] m_a, m_b;
    logic         l_valid, l_ready, l_abort, l_clr, l_sv, l_sa, l_sb, l_sf, l_sl;
    logic [W-1:0] l_a, l_b;

    typedef struct packed {
        logic clr;
        logic a;
        logic b;
        logic first;
        logic last;
    } item_t;

    item_t q_m[$];
    item_t q_l[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic  lst;

    always #5 clk = ~clk;

    serial_pair_serializer_msb_first #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(m_ready),
        .in_a(m_a), .in_b(m_b), .abort(m_abort), .cmp_clear(m_clr),
        .ser_valid(m_sv), .ser_a(m_sa), .ser_b(m_sb),
        .ser_first(m_sf), .ser_last(m_sl)
    );

    serial_pair_serializer_msb_first #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_valid(l_valid), .in_ready(l_ready),
        .in_a(l_a), .in_b(l_b), .abort(l_abort), .cmp_clear(l_clr),
        .ser_valid(l_sv), .ser_a(l_sa), .ser_b(l_sb),
        .ser_first(l_sf), .ser_last(l_sl)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected items: one clear, then nbits bit pairs in shift order.
    task automatic push_frame(input int inst, input logic [W-1:0] a, input logic [W-1:0] b,
                              input int nbits);
        item_t it;
        int    k;
        it = 5'b10000;
        if (inst == 0) q_m.push_back(it); else q_l.push_back(it);
        for (int i = 0; i < nbits; i++) begin
            k        = (inst == 0) ? (W - 1 - i) : i;
            it.clr   = 1'b0;
            it.a     = a[k];
            it.b     = b[k];
            it.first = (i == 0);
            it.last  = (i == W - 1);
            if (inst == 0) q_m.push_back(it); else q_l.push_back(it);
        end
    endtask

    task automatic mon(input int inst, input logic clr, input logic sv, input logic sa,
                       input logic sb, input logic sf, input logic sl);
        item_t got;
        item_t exp;
        int    sz;
        got = {clr, sa, sb, sf, sl};
        if (clr || sv) begin
            sz = (inst == 0) ? q_m.size() : q_l.size();
            if (sz == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output inst%0d: got %b expected none at %0t",
                         inst, got, $time);
            end else begin
                if (inst == 0) exp = q_m.pop_front(); else exp = q_l.pop_front();
                chk($sformatf("frame_item_inst%0d", inst), got, exp);
            end
        end else begin
            chk($sformatf("quiet_outputs_inst%0d", inst), {sa, sb, sf, sl}, 4'b0000);
        end
    endtask

    // Monitor: sampled on the inactive edge, only while out of reset.
    always @(negedge clk) begin
        if (rst) begin
            mon(0, m_clr, m_sv, m_sa, m_sb, m_sf, m_sl);
            mon(1, l_clr, l_sv, l_sa, l_sb, l_sf, l_sl);
        end
    end

    // Present a pair until accepted; caller is at posedge+1, returns at posedge+1.
    task automatic send(input int inst, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int nbits, output logic last_at_acc);
        bit   done;
        logic rdy;
        logic sl;
        done        = 1'b0;
        last_at_acc = 1'b0;
        if (inst == 0) begin m_valid = 1'b1; m_a = a; m_b = b; end
        else           begin l_valid = 1'b1; l_a = a; l_b = b; end
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            rdy = (inst == 0) ? m_ready : l_ready;
            sl  = (inst == 0) ? m_sl : l_sl;
            @(posedge clk);
            #1;
            if (rdy) begin
                done        = 1'b1;
                last_at_acc = sl;
                push_frame(inst, a, b, nbits);
            end
        end
        if (inst == 0) m_valid = 1'b0; else l_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout inst%0d: got no accept expected accept", inst);
        end
    endtask

    task automatic drain(input int inst);
        int sz;
        sz = 1;
        for (int c = 0; c < 200 && sz != 0; c++) begin
            @(negedge clk);
            sz = (inst == 0) ? q_m.size() : q_l.size();
        end
        chk($sformatf("drain_inst%0d", inst), sz, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_valid = 1'b0; m_abort = 1'b0; m_a = '0; m_b = '0;
        l_valid = 1'b0; l_abort = 1'b0; l_a = '0; l_b = '0;

        // Reset held, then idle with in_valid low.
        repeat (3) begin
            @(negedge clk);
            chk("reset_ready", {m_ready, l_ready}, 2'b11);
            chk("reset_outs", {m_clr, m_sv, m_sa, m_sb, m_sf, m_sl,
                               l_clr, l_sv, l_sa, l_sb, l_sf, l_sl}, 12'h000);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_ready", {m_ready, l_ready}, 2'b11);
            chk("idle_outs", {m_clr, m_sv, l_clr, l_sv}, 4'h0);
        end
        @(posedge clk);
        #1;

        // Single MSB-first frame.
        send(0, 16'b0110_0100_1000_0010, 16'b0110_0010_0110_0010, W, lst);
        drain(0);

        // Back-to-back: second pair accepted on the first frame's last bit.
        send(0, 16'h1234, 16'h00F0, W, lst);
        send(0, 16'hFFFF, 16'h0001, W, lst);
        chk("b2b_accept_on_last", lst, 1'b1);
        @(negedge clk);
        chk("b2b_clear_no_gap", m_clr, 1'b1);
        drain(0);

        // LSB-first instance: first pair (1,0), last pair (0,1).
        send(1, 16'h0001, 16'h8000, W, lst);
        drain(1);

        // Abort on the 6th SHIFT cycle, then a full restart.
        send(0, 16'hA5C3, 16'h3C5A, 6, lst);
        repeat (6) @(posedge clk);
        #1;
        m_abort = 1'b1;
        @(negedge clk);
        chk("abort_cycle_valid", m_sv, 1'b1);
        chk("abort_cycle_ready", m_ready, 1'b0);
        @(posedge clk);
        #1;
        m_abort = 1'b0;
        @(negedge clk);
        chk("abort_next_valid", {m_sv, m_clr}, 2'b00);
        chk("abort_next_ready", m_ready, 1'b1);
        @(posedge clk);
        #1;
        send(0, 16'h8001, 16'h7FFE, W, lst);
        drain(0);

        // Abort on ser_last with in_valid high: no accept may coincide.
        send(0, 16'h00FF, 16'hFF00, W, lst);
        repeat (16) @(posedge clk);
        #1;
        m_abort = 1'b1;
        m_valid = 1'b1;
        m_a     = 16'h1111;
        m_b     = 16'h2222;
        @(negedge clk);
        chk("abort_last_ready", m_ready, 1'b0);
        @(posedge clk);
        #1;
        m_abort = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        chk("abort_last_no_accept", {m_clr, m_sv}, 2'b00);
        chk("abort_last_ready_back", m_ready, 1'b1);
        @(posedge clk);
        #1;

        // Asynchronous reset between edges during SHIFT.
        send(0, 16'hC3A5, 16'h5A3C, 2, lst);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_valid", m_sv, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_ready", m_ready, 1'b1);
        chk("async_rst_outs", {m_clr, m_sv, m_sa, m_sb, m_sf, m_sl}, 6'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("async_no_residual", q_m.size(), 0);

        chk("final_queue_m", q_m.size(), 0);
        chk("final_queue_l", q_l.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
